count_uart_tx: RTL and testbench



---
 rtl/count_uart_pkg.sv | 18 +
 rtl/count_uart_tx_if.sv | 11 +
 rtl/count_uart_baud.sv | 38 +++
 rtl/count_uart_tx.sv | 108 ++++++++++
 tb/tb_count_uart_tx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/count_uart_pkg.sv
// Shared constants and types for the counter-to-UART serial transmitter.
package count_uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned STATE_W   = 2;

  typedef logic [DATA_BITS-1:0] byte_t;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_START = 2'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 2'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 2'd3;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/count_uart_tx_if.sv
// Byte handshake between the upstream counter and the serial transmitter.
interface count_uart_tx_if;

  count_uart_pkg::byte_t in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/count_uart_baud.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while running, held at 0 otherwise.
module count_uart_baud #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_tick,
  output logic pre_tick_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // pre_tick_c lets the parent register a pulse that lands on the last cycle of a bit
  assign bit_tick   = run && (cnt_q == CNT_LAST);
  assign pre_tick_c = run && (cnt_q == CNT_PRE);

endmodule

// File: rtl/count_uart_tx.sv
// 8N1 serial transmitter for the counter value; tx/busy/tx_done are registered.
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  count_uart_tx_if.slave    in_if,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  logic [STATE_W-1:0] state_q, state_d;
  byte_t              shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               tx_done_q, tx_done_d;

  logic in_ready_c;
  logic run_c;
  logic bit_tick;
  logic pre_tick_c;

  assign in_ready_c = (state_q == ST_IDLE);
  assign run_c      = !in_ready_c;

  count_uart_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .run       (run_c),
    .bit_tick  (bit_tick),
    .pre_tick_c(pre_tick_c)
  );

  // Frame sequencing, shift register and bit index
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_if.in_valid) begin
          shift_d = in_if.in_data;
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state
  always_comb begin
    tx_d = STOP_LVL;
    case (state_d)
      ST_START: tx_d = START_LVL;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = STOP_LVL;
    endcase
    busy_d    = (state_d != ST_IDLE);
    tx_done_d = (state_q == ST_STOP) && pre_tick_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      tx_q      <= STOP_LVL;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign in_if.in_ready = in_ready_c;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign tx_done        = tx_done_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Scoreboard bench: bytes pushed on acceptance, popped when a full frame is decoded off tx.
module tb_count_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  count_uart_tx_if u_if4 ();
  count_uart_tx_if u_if2 ();

  logic tx4, busy4, done4;
  logic tx2, busy2, done2;

  count_uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .reset(rst), .in_if(u_if4.slave),
    .tx(tx4), .busy(busy4), .tx_done(done4)
  );

  count_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .reset(rst), .in_if(u_if2.slave),
    .tx(tx2), .busy(busy2), .tx_done(done2)
  );

  bit   sel = 1'b0;
  logic tx_m, busy_m, done_m, in_ready_m;
  assign tx_m       = sel ? tx2   : tx4;
  assign busy_m     = sel ? busy2 : busy4;
  assign done_m     = sel ? done2 : done4;
  assign in_ready_m = sel ? u_if2.in_ready : u_if4.in_ready;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  logic [7:0] cnt_val = 8'hF0;
  bit         cnt_en  = 1'b0;
  always @(posedge clk) if (cnt_en) cnt_val <= cnt_val + 8'd1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Frame monitor
  int         frames_rx = 0;
  bit         in_frame = 1'b0, post_chk = 1'b0, gap_en = 1'b0, gap_armed = 1'b0, consistent;
  int         k, cpb, done_k, done_cnt, hi_run = 0, hi_at_start;
  logic [9:0] slots;
  logic [7:0] exp_b;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cpb = sel ? 2 : 4;
      if (post_chk) begin
        check_eq("busy_after_frame", busy_m, 1'b0);
        post_chk = 1'b0;
      end
      if (rst) begin
        in_frame = 1'b0; hi_run = 0; gap_armed = 1'b0;
      end else begin
        if (!in_frame) begin
          if (tx_m == 1'b0) begin
            in_frame = 1'b1; k = 0; hi_at_start = hi_run; hi_run = 0;
            done_cnt = 0; done_k = -1; consistent = 1'b1; slots = '0;
            if (gap_armed) check_eq("idle_high_gap", hi_at_start, cpb + 1);
          end else begin
            hi_run++;
          end
        end
        if (in_frame) begin
          if (k == 9 * cpb) hi_run = 0;
          if (tx_m === 1'b1) hi_run++; else hi_run = 0;
          if (k % cpb == 0) slots[k / cpb] = tx_m;
          else if (tx_m !== slots[k / cpb]) consistent = 1'b0;
          if (done_m) begin done_cnt++; done_k = k; end
          if (k == 10 * cpb - 1) begin
            frames_rx++;
            check_eq("slot_stable", consistent, 1'b1);
            check_eq("done_position", done_k, 10 * cpb - 1);
            check_eq("done_count", done_cnt, 1);
            check_eq("busy_last_cycle", busy_m, 1'b1);
            check_eq("exp_available", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
              exp_b = exp_q.pop_front();
              check_eq("frame_bits", slots, {1'b1, exp_b, 1'b0});
            end
            in_frame  = 1'b0;
            post_chk  = 1'b1;
            gap_armed = gap_en;
          end
          k++;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    if (sel) begin u_if2.in_valid = v; u_if2.in_data = d; end
    else     begin u_if4.in_valid = v; u_if4.in_data = d; end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!in_ready_m && t < 200) begin step(); t++; end
    check_eq("ready_before_send", in_ready_m, 1'b1);
    drive(1'b1, b);
    exp_q.push_back(b);
    step();
    drive(1'b0, b);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_rx < n && t < 2000) begin step(); t++; end
    check_eq("frames_received", frames_rx, n);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int   pushes;
    int   t;
    logic done_seen;

    u_if2.in_valid = 1'b0; u_if2.in_data = 8'h00;
    u_if4.in_valid = 1'b1; u_if4.in_data = 8'h55;
    rst = 1'b1;
    step(); step();
    check_eq("reset_tx", tx4, 1'b1);
    check_eq("reset_in_ready", u_if4.in_ready, 1'b1);
    check_eq("reset_busy", busy4, 1'b0);
    check_eq("reset_tx_done", done4, 1'b0);
    check_eq("reset_tx_min", tx2, 1'b1);
    drive(1'b0, 8'h00);
    rst = 1'b0;
    step(); step();
    check_eq("idle_after_reset", busy4, 1'b0);

    send(8'hA5);
    wait_frames(1);
    step();

    send(8'h3C);
    repeat (10) step();
    drive(1'b1, 8'hFF);
    step();
    drive(1'b0, 8'hFF);
    wait_frames(2);
    repeat (8) step();
    check_eq("no_second_accept", busy4, 1'b0);
    check_eq("queue_empty", exp_q.size(), 0);

    cnt_en = 1'b1;
    gap_en = 1'b1;
    pushes = 0;
    t = 0;
    while (pushes < 3 && t < 500) begin
      drive(1'b1, cnt_val);
      if (in_ready_m) begin exp_q.push_back(cnt_val); pushes++; end
      step();
      t++;
    end
    drive(1'b0, cnt_val);
    gap_en = 1'b0;
    cnt_en = 1'b0;
    wait_frames(5);
    repeat (3) step();

    send(8'h5A);
    repeat (17) step();
    rst = 1'b1;
    step();
    check_eq("abort_tx", tx4, 1'b1);
    check_eq("abort_busy", busy4, 1'b0);
    done_seen = done4;
    rst = 1'b0;
    void'(exp_q.pop_back());
    repeat (12) begin step(); done_seen = done_seen | done4; end
    check_eq("abort_no_done", done_seen, 1'b0);
    check_eq("abort_frames_unchanged", frames_rx, 5);
    send(8'h01);
    wait_frames(6);
    repeat (3) step();

    sel = 1'b1;
    step();
    send(8'h00);
    wait_frames(7);
    repeat (3) step();
    check_eq("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
